spi_cmd_rx: RTL and testbench
=============================

SPI_CMD_RX -- requirements
Module: spi_cmd_rx

Interface
REQ-001 Parameter: SYNC_STAGES, default 2, number of flip-flop synchronizer stages on SCK, CS_N and MOSI (legal 2..3).
REQ-002 Parameter: FRAME_BITS, default 64, bits per command frame (16 cmd + 8 addr + 40 data); only 64 is supported.
REQ-003 Port: clk  input  1  system clock; all logic SHALL be in this single clock domain.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: SCK  input  1  asynchronous SPI clock from the host MCU; mode 0 (idle low, sample on rising edge).
REQ-006 Port: CS_N  input  1  asynchronous SPI chip select, active low, frames one command.
REQ-007 Port: MOSI  input  1  asynchronous SPI serial data, MSB first.
REQ-008 Port: spi_cmd_r  output  16  command field of the last complete frame.
REQ-009 Port: spi_addr_r  output  8  address (slot/device ID) field of the last complete frame.
REQ-010 Port: spi_data_r  output  40  data field of the last complete frame.
REQ-011 Port: spi_data_valid_r  output  1  single-clk pulse marking the cycle in which new cmd/addr/data are presented.
REQ-012 Port: frame_err  output  1  single-clk pulse: frame ended with a bit count other than 64.

Function
REQ-013 SCK, CS_N and MOSI SHALL each pass through SYNC_STAGES flops; edges SHALL be detected on synchronized values only.
REQ-014 States: IDLE, SHIFT, HOLD. IDLE->SHIFT on synchronized CS_N falling edge; bit counter (7 bits) and shift register cleared on entry.
REQ-015 In SHIFT, each synchronized SCK rising edge SHALL shift the synchronized MOSI value into bit 0 of a 64-bit shift register and increment the counter.
REQ-016 When the counter reaches 64, the state SHALL go to HOLD and, in the next clk, bits [63:48]->spi_cmd_r, [47:40]->spi_addr_r, [39:0]->spi_data_r, with spi_data_valid_r high for exactly that one cycle.
REQ-017 In HOLD, further SCK edges SHALL be ignored; return to IDLE on CS_N rising edge, with no error.
REQ-018 CS_N rising edge in SHIFT with counter != 64 (including 0) SHALL pulse frame_err for one cycle, return to IDLE and leave outputs unchanged, with no valid pulse.
REQ-019 spi_cmd_r/addr_r/data_r SHALL hold their value between frames; they change only in the valid cycle.
REQ-020 SCK rising edge and CS_N rising edge detected in the same clk: the SCK bit SHALL be counted first, then the CS_N rule applied (bit 64 plus CS high yields a valid frame).
REQ-021 CS_N falling edge while in HOLD (missed rising edge impossible post-sync) SHALL be treated as a new frame start.
REQ-022 Latency: valid SHALL assert SYNC_STAGES+2 clk after the 64th SCK rising edge at the pins, ±1 clk.
REQ-023 Requirement on clk: clk SHALL be at least 4x SCK frequency; the block is not required to work below this ratio.

Reset
REQ-024 On reset: state IDLE, counter 0, shift register 0, spi_cmd_r=0, spi_addr_r=0, spi_data_r=0, spi_data_valid_r=0, frame_err=0, synchronizers loaded with idle levels (SCK=0, CS_N=1, MOSI=0).
REQ-025 Reset asserted mid-frame SHALL discard the partial frame; after release the block SHALL wait for a fresh CS_N falling edge (an already-low CS_N SHALL NOT start a frame).

Structure
REQ-026 Frame field widths/offsets (CMD_W=16, ADDR_W=8, DATA_W=40) SHALL live in the shared commands include next to the C_* command codes.
REQ-027 A single sub-module, sync_edge (N-stage synchronizer with rise/fall pulse outputs), SHALL be instantiated for SCK and CS_N; MOSI uses its synchronized output only.

Verification
REQ-028 Frame cmd=16'h0123, addr=8'h02, data=40'hAB_CDEF_0001 at clk/8 SCK -> one valid pulse; outputs equal those values; frame_err stays 0.
REQ-029 CS_N deasserted after 40 bits -> frame_err pulse, no valid, outputs retain previous frame values.
REQ-030 70 SCK pulses in one CS_N window, first 64 carrying cmd=16'hFFFF, addr=8'h00, data=40'h0 -> one valid with those values; extra 6 bits ignored; no error.
REQ-031 Two back-to-back frames with one-clk CS_N high gap (post-sync ≥ 1 cycle) -> two valid pulses with the correct, distinct contents.
REQ-032 Reset asserted at bit 30 and released while CS_N is still low, followed by the remaining clocks -> no valid, no error until the next full CS_N low frame, which decodes correctly.
REQ-033 64th SCK rising edge coincident (same synchronized cycle) with CS_N rising edge -> valid pulse with correct data, no frame_err.

Source files
------------

// File: rtl/spi_cmd_rx_pkg.sv
// spi_cmd_rx_pkg
// Shared definitions for the SPI command receiver: frame field widths and
// bit offsets inside the 64-bit frame, the command codes the host may send,
// and the receiver FSM state type.
package spi_cmd_rx_pkg;

   // Frame layout, MSB first on the wire: cmd | addr | data
   localparam int CMD_W    = 16;
   localparam int ADDR_W   = 8;
   localparam int DATA_W   = 40;
   localparam int FRAME_W  = CMD_W + ADDR_W + DATA_W;
   localparam int CMD_LSB  = ADDR_W + DATA_W;
   localparam int ADDR_LSB = DATA_W;
   localparam int DATA_LSB = 0;

   // Command codes understood by the downstream decoder
   localparam logic [CMD_W-1:0] C_NOP        = 16'h0000;
   localparam logic [CMD_W-1:0] C_SLOT_WRITE = 16'h0123;
   localparam logic [CMD_W-1:0] C_SLOT_READ  = 16'h0124;
   localparam logic [CMD_W-1:0] C_BROADCAST  = 16'hFFFF;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      HOLD
   } state_t;

endpackage

// File: rtl/spi_cmd_rx_sync_edge.sv
// sync_edge
// N-stage flip-flop synchronizer for one asynchronous input, followed by an
// edge detector working purely on the synchronized value.
// Ports:
//   clk      system clock
//   reset    synchronous active-high reset, loads RESET_VAL into every stage
//   din      asynchronous input
//   sync_out synchronized level
//   rise     one-cycle pulse on a synchronized 0->1 transition
//   fall     one-cycle pulse on a synchronized 1->0 transition
module sync_edge #(
   parameter int   STAGES    = 2,
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic sync_out,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] chain_q, chain_d;
   logic              prev_q, prev_d;

   always_comb begin
      chain_d = {chain_q[STAGES-2:0], din};
      prev_d  = chain_q[STAGES-1];
   end

   // Reset to the idle level so no spurious edge appears after reset
   always_ff @(posedge clk) begin
      if (reset) begin
         chain_q <= {STAGES{RESET_VAL}};
         prev_q  <= RESET_VAL;
      end else begin
         chain_q <= chain_d;
         prev_q  <= prev_d;
      end
   end

   assign sync_out = chain_q[STAGES-1];
   assign rise     = sync_out & ~prev_q;
   assign fall     = ~sync_out & prev_q;

endmodule

// File: rtl/spi_cmd_rx.sv
// spi_cmd_rx
// SPI mode-0 slave receiver for fixed 64-bit command frames. SCK, CS_N and
// MOSI are oversampled in the clk domain; each frame is split into
// cmd/addr/data and presented with a one-cycle valid pulse. Frames ended
// early by CS_N produce a one-cycle frame_err pulse instead.
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   SCK, CS_N, MOSI   asynchronous SPI pins from the host
//   spi_cmd_r         command field of the last complete frame
//   spi_addr_r        address field of the last complete frame
//   spi_data_r        data field of the last complete frame
//   spi_data_valid_r  one-cycle pulse when new fields are presented
//   frame_err         one-cycle pulse when a frame ends with != 64 bits
module spi_cmd_rx
   import spi_cmd_rx_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int FRAME_BITS  = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              SCK,
   input  logic              CS_N,
   input  logic              MOSI,
   output logic [CMD_W-1:0]  spi_cmd_r,
   output logic [ADDR_W-1:0] spi_addr_r,
   output logic [DATA_W-1:0] spi_data_r,
   output logic              spi_data_valid_r,
   output logic              frame_err
);

   localparam logic [6:0] FRAME_CNT  = 7'(FRAME_BITS);
   localparam logic [1:0] FLUSH_DONE = 2'(SYNC_STAGES);

   logic sck_rise, sck_sync_unused, sck_fall_unused;
   logic cs_sync, cs_rise, cs_fall;

   sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck_sync (
      .clk      (clk),
      .reset    (reset),
      .din      (SCK),
      .sync_out (sck_sync_unused),
      .rise     (sck_rise),
      .fall     (sck_fall_unused)
   );

   sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
      .clk      (clk),
      .reset    (reset),
      .din      (CS_N),
      .sync_out (cs_sync),
      .rise     (cs_rise),
      .fall     (cs_fall)
   );

   // MOSI goes through the same depth as SCK so the bit is aligned with
   // the detected SCK rising edge
   logic [SYNC_STAGES-1:0] mosi_q, mosi_d;
   logic                   mosi_sync;

   state_t              state_q, state_d;
   logic [6:0]          cnt_q, cnt_d, cnt_next;
   logic [FRAME_W-1:0]  shreg_q, shreg_d, shreg_next;
   logic [CMD_W-1:0]    cmd_q, cmd_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic                valid_q, valid_d;
   logic                err_q, err_d;
   logic [1:0]          flush_q, flush_d;
   logic                armed_q, armed_d;
   logic                flushed;

   assign mosi_sync = mosi_q[SYNC_STAGES-1];
   assign flushed   = (flush_q == FLUSH_DONE);

   // A CS_N that is already low when reset releases shows up as a fake
   // falling edge once the synchronizer flushes its idle-level reset value.
   // Frames are only accepted after CS_N has been seen high with real data
   // in the synchronizer.
   always_comb begin
      mosi_d  = {mosi_q[SYNC_STAGES-2:0], MOSI};
      flush_d = flushed ? flush_q : flush_q + 2'd1;
      armed_d = armed_q | (flushed & cs_sync);
   end

   // Next-state and datapath. The SCK bit of a cycle is always accounted
   // before CS_N is judged, so the 64th edge coincident with CS_N rising
   // still yields a valid frame.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      shreg_d    = shreg_q;
      cmd_d      = cmd_q;
      addr_d     = addr_q;
      data_d     = data_q;
      valid_d    = 1'b0;
      err_d      = 1'b0;
      shreg_next = sck_rise ? {shreg_q[FRAME_W-2:0], mosi_sync} : shreg_q;
      cnt_next   = sck_rise ? cnt_q + 7'd1 : cnt_q;

      case (state_q)
         IDLE: begin
            if (cs_fall && armed_q) begin
               state_d = SHIFT;
               cnt_d   = '0;
               shreg_d = '0;
            end
         end
         SHIFT: begin
            cnt_d   = cnt_next;
            shreg_d = shreg_next;
            if (cnt_next == FRAME_CNT) begin
               cmd_d   = shreg_next[CMD_LSB +: CMD_W];
               addr_d  = shreg_next[ADDR_LSB +: ADDR_W];
               data_d  = shreg_next[DATA_LSB +: DATA_W];
               valid_d = 1'b1;
               state_d = cs_rise ? IDLE : HOLD;
            end else if (cs_rise) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end
         end
         HOLD: begin
            if (cs_fall) begin
               state_d = SHIFT;
               cnt_d   = '0;
               shreg_d = '0;
            end else if (cs_rise) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // All state registers, cleared by the synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         mosi_q  <= '0;
         state_q <= IDLE;
         cnt_q   <= '0;
         shreg_q <= '0;
         cmd_q   <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         flush_q <= '0;
         armed_q <= 1'b0;
      end else begin
         mosi_q  <= mosi_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shreg_q <= shreg_d;
         cmd_q   <= cmd_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         err_q   <= err_d;
         flush_q <= flush_d;
         armed_q <= armed_d;
      end
   end

   assign spi_cmd_r        = cmd_q;
   assign spi_addr_r       = addr_q;
   assign spi_data_r       = data_q;
   assign spi_data_valid_r = valid_q;
   assign frame_err        = err_q;

endmodule

// File: tb/tb_spi_cmd_rx.sv
// tb_spi_cmd_rx
// Self-checking bench for spi_cmd_rx. Expected frames are queued when a
// frame is driven and compared by a monitor when the valid pulse appears;
// each scenario task also checks pulse counts and held output values.
module tb_spi_cmd_rx;

   localparam int SYNC = 2;

   typedef struct packed {
      logic [15:0] cmd;
      logic [7:0]  addr;
      logic [39:0] data;
   } frame_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        SCK = 1'b0;
   logic        CS_N = 1'b1;
   logic        MOSI = 1'b0;
   logic [15:0] spi_cmd_r;
   logic [7:0]  spi_addr_r;
   logic [39:0] spi_data_r;
   logic        spi_data_valid_r;
   logic        frame_err;

   int     total = 0;
   int     bad = 0;
   int     valid_seen = 0;
   int     err_seen = 0;
   frame_t exp_q[$];
   frame_t mon_f;
   frame_t last_exp = '0;

   spi_cmd_rx #(.SYNC_STAGES(SYNC), .FRAME_BITS(64)) dut (
      .clk              (clk),
      .reset            (reset),
      .SCK              (SCK),
      .CS_N             (CS_N),
      .MOSI             (MOSI),
      .spi_cmd_r        (spi_cmd_r),
      .spi_addr_r       (spi_addr_r),
      .spi_data_r       (spi_data_r),
      .spi_data_valid_r (spi_data_valid_r),
      .frame_err        (frame_err)
   );

   always #5 clk = ~clk;

   // Monitor: compare each valid frame against the oldest queued frame
   always @(posedge clk) begin
      #1;
      if (!reset) begin
         if (spi_data_valid_r === 1'b1) begin
            valid_seen++;
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("[TB] FAIL unexpected_valid: got cmd=%h addr=%h data=%h, required no valid", spi_cmd_r, spi_addr_r, spi_data_r);
            end else begin
               mon_f = exp_q.pop_front();
               if (spi_cmd_r !== mon_f.cmd || spi_addr_r !== mon_f.addr || spi_data_r !== mon_f.data) begin
                  bad++;
                  $display("[TB] FAIL frame_content: got %h/%h/%h required %h/%h/%h", spi_cmd_r, spi_addr_r, spi_data_r, mon_f.cmd, mon_f.addr, mon_f.data);
               end
            end
         end
         if (frame_err === 1'b1) err_seen++;
      end
   end

   task automatic drive_bit(input logic b);
      MOSI = b;
      repeat (4) @(negedge clk);
      SCK = 1'b1;
      repeat (4) @(negedge clk);
      SCK = 1'b0;
   endtask

   // Drives a frame of nbits; bits past 64 are ones
   task automatic send_frame(input logic [63:0] v, input int nbits);
      CS_N = 1'b0;
      repeat (4) @(negedge clk);
      for (int i = 0; i < nbits; i++) drive_bit((i < 64) ? v[63-i] : 1'b1);
      repeat (4) @(negedge clk);
      CS_N = 1'b1;
      repeat (8) @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      total++; if (spi_cmd_r !== 16'h0) begin bad++; $display("[TB] FAIL reset_cmd: got %h required 0", spi_cmd_r); end
      total++; if (spi_addr_r !== 8'h0) begin bad++; $display("[TB] FAIL reset_addr: got %h required 0", spi_addr_r); end
      total++; if (spi_data_r !== 40'h0) begin bad++; $display("[TB] FAIL reset_data: got %h required 0", spi_data_r); end
      total++; if (spi_data_valid_r !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %b required 0", spi_data_valid_r); end
      total++; if (frame_err !== 1'b0) begin bad++; $display("[TB] FAIL reset_err: got %b required 0", frame_err); end
      reset = 1'b0;
      repeat (10) @(negedge clk);
   endtask

   task automatic test_basic();
      frame_t f;
      int v0, e0, lat;
      f = '{cmd: 16'h0123, addr: 8'h02, data: 40'hAB_CDEF_0001};
      v0 = valid_seen; e0 = err_seen;
      exp_q.push_back(f);
      CS_N = 1'b0;
      repeat (4) @(negedge clk);
      for (int i = 0; i < 63; i++) drive_bit(f[63-i]);
      MOSI = f[0];
      repeat (4) @(negedge clk);
      SCK = 1'b1;
      lat = 0;
      while (valid_seen == v0 && lat < 12) begin
         @(negedge clk);
         lat++;
      end
      total++;
      if (lat < SYNC + 1 || lat > SYNC + 3) begin
         bad++; $display("[TB] FAIL basic_latency: got %0d clk required %0d..%0d", lat, SYNC + 1, SYNC + 3);
      end
      repeat (4) @(negedge clk);
      SCK = 1'b0;
      repeat (4) @(negedge clk);
      CS_N = 1'b1;
      repeat (8) @(negedge clk);
      last_exp = f;
      total++; if (valid_seen - v0 !== 1) begin bad++; $display("[TB] FAIL basic_valid_count: got %0d required 1", valid_seen - v0); end
      total++; if (err_seen - e0 !== 0) begin bad++; $display("[TB] FAIL basic_err_count: got %0d required 0", err_seen - e0); end
      total++; if ({spi_cmd_r, spi_addr_r, spi_data_r} !== 64'(last_exp)) begin bad++; $display("[TB] FAIL basic_hold: got %h required %h", {spi_cmd_r, spi_addr_r, spi_data_r}, last_exp); end
   endtask

   task automatic test_short_frame();
      int v0, e0;
      v0 = valid_seen; e0 = err_seen;
      send_frame(64'h5555_AAAA_5555_AAAA, 40);
      total++; if (err_seen - e0 !== 1) begin bad++; $display("[TB] FAIL short_err_count: got %0d required 1", err_seen - e0); end
      total++; if (valid_seen - v0 !== 0) begin bad++; $display("[TB] FAIL short_valid_count: got %0d required 0", valid_seen - v0); end
      total++; if ({spi_cmd_r, spi_addr_r, spi_data_r} !== 64'(last_exp)) begin bad++; $display("[TB] FAIL short_hold: got %h required %h", {spi_cmd_r, spi_addr_r, spi_data_r}, last_exp); end
   endtask

   task automatic test_long_frame();
      frame_t f;
      int v0, e0;
      f = '{cmd: 16'hFFFF, addr: 8'h00, data: 40'h0};
      v0 = valid_seen; e0 = err_seen;
      exp_q.push_back(f);
      send_frame(f, 70);
      last_exp = f;
      total++; if (valid_seen - v0 !== 1) begin bad++; $display("[TB] FAIL long_valid_count: got %0d required 1", valid_seen - v0); end
      total++; if (err_seen - e0 !== 0) begin bad++; $display("[TB] FAIL long_err_count: got %0d required 0", err_seen - e0); end
      total++; if ({spi_cmd_r, spi_addr_r, spi_data_r} !== 64'(last_exp)) begin bad++; $display("[TB] FAIL long_hold: got %h required %h", {spi_cmd_r, spi_addr_r, spi_data_r}, last_exp); end
   endtask

   task automatic test_back_to_back();
      frame_t fa, fb;
      int v0, e0;
      fa = '{cmd: 16'hC0DE, addr: 8'h5A, data: 40'h12_3456_789A};
      fb = '{cmd: 16'h0F0F, addr: 8'hA5, data: 40'hFE_DCBA_9876};
      v0 = valid_seen; e0 = err_seen;
      exp_q.push_back(fa);
      exp_q.push_back(fb);
      CS_N = 1'b0;
      repeat (4) @(negedge clk);
      for (int i = 0; i < 64; i++) drive_bit(fa[63-i]);
      repeat (4) @(negedge clk);
      CS_N = 1'b1;
      @(negedge clk);
      CS_N = 1'b0;
      repeat (4) @(negedge clk);
      for (int i = 0; i < 64; i++) drive_bit(fb[63-i]);
      repeat (4) @(negedge clk);
      CS_N = 1'b1;
      repeat (8) @(negedge clk);
      last_exp = fb;
      total++; if (valid_seen - v0 !== 2) begin bad++; $display("[TB] FAIL b2b_valid_count: got %0d required 2", valid_seen - v0); end
      total++; if (err_seen - e0 !== 0) begin bad++; $display("[TB] FAIL b2b_err_count: got %0d required 0", err_seen - e0); end
      total++; if ({spi_cmd_r, spi_addr_r, spi_data_r} !== 64'(last_exp)) begin bad++; $display("[TB] FAIL b2b_hold: got %h required %h", {spi_cmd_r, spi_addr_r, spi_data_r}, last_exp); end
   endtask

   task automatic test_reset_mid_frame();
      frame_t fp, fn;
      int v0, e0;
      fp = '{cmd: 16'h7777, addr: 8'h33, data: 40'h11_2233_4455};
      fn = '{cmd: 16'h1357, addr: 8'h24, data: 40'h00_FFFF_0000};
      v0 = valid_seen; e0 = err_seen;
      CS_N = 1'b0;
      repeat (4) @(negedge clk);
      for (int i = 0; i < 30; i++) drive_bit(fp[63-i]);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      for (int i = 30; i < 64; i++) drive_bit(fp[63-i]);
      repeat (4) @(negedge clk);
      CS_N = 1'b1;
      repeat (8) @(negedge clk);
      last_exp = '0;
      total++; if (valid_seen - v0 !== 0) begin bad++; $display("[TB] FAIL rstmid_valid_count: got %0d required 0", valid_seen - v0); end
      total++; if (err_seen - e0 !== 0) begin bad++; $display("[TB] FAIL rstmid_err_count: got %0d required 0", err_seen - e0); end
      total++; if ({spi_cmd_r, spi_addr_r, spi_data_r} !== 64'(last_exp)) begin bad++; $display("[TB] FAIL rstmid_cleared: got %h required %h", {spi_cmd_r, spi_addr_r, spi_data_r}, last_exp); end
      exp_q.push_back(fn);
      send_frame(fn, 64);
      last_exp = fn;
      total++; if (valid_seen - v0 !== 1) begin bad++; $display("[TB] FAIL rstmid_next_valid: got %0d required 1", valid_seen - v0); end
      total++; if ({spi_cmd_r, spi_addr_r, spi_data_r} !== 64'(last_exp)) begin bad++; $display("[TB] FAIL rstmid_next_hold: got %h required %h", {spi_cmd_r, spi_addr_r, spi_data_r}, last_exp); end
   endtask

   task automatic test_coincident_end();
      frame_t f;
      int v0, e0;
      f = '{cmd: 16'h8001, addr: 8'h81, data: 40'h80_0000_0001};
      v0 = valid_seen; e0 = err_seen;
      exp_q.push_back(f);
      CS_N = 1'b0;
      repeat (4) @(negedge clk);
      for (int i = 0; i < 63; i++) drive_bit(f[63-i]);
      MOSI = f[0];
      repeat (4) @(negedge clk);
      SCK = 1'b1;
      CS_N = 1'b1;
      repeat (4) @(negedge clk);
      SCK = 1'b0;
      repeat (8) @(negedge clk);
      last_exp = f;
      total++; if (valid_seen - v0 !== 1) begin bad++; $display("[TB] FAIL coinc_valid_count: got %0d required 1", valid_seen - v0); end
      total++; if (err_seen - e0 !== 0) begin bad++; $display("[TB] FAIL coinc_err_count: got %0d required 0", err_seen - e0); end
      total++; if ({spi_cmd_r, spi_addr_r, spi_data_r} !== 64'(last_exp)) begin bad++; $display("[TB] FAIL coinc_hold: got %h required %h", {spi_cmd_r, spi_addr_r, spi_data_r}, last_exp); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_short_frame();
      test_long_frame();
      test_back_to_back();
      test_reset_mid_frame();
      test_coincident_end();
      repeat (4) @(negedge clk);
      total++;
      if (exp_q.size() != 0) begin
         bad++; $display("[TB] FAIL scoreboard_drain: got %0d frames pending required 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
